// File: rtl/ycr1_wb_burst_master.sv
// Wishbone burst master: turns one line-transfer request into a single
// Wishbone burst (constant stb/adr/bl/we for the whole burst), streams read
// beats out and write words in, and reports completion with an error flag.
// Optional no-ack watchdog is enabled by defining YCR1_WB_TIMEOUT_EN.
// Write data: wbd_dat_o is wdat_i registered, so after a pop the next word
// reaches the bus one cycle after the upstream buffer presents it.

module ycr1_wb_burst_master #(
    parameter int unsigned MAX_BL      = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [9:0]  req_len_i,

    input  logic [31:0] wdat_i,
    output logic        wdat_pop_o,

    output logic [31:0] rdat_o,
    output logic        rdat_valid_o,
    output logic        rdat_last_o,

    output logic        done_o,
    output logic        err_o,

    output logic        wbd_stb_o,
    output logic        wbd_we_o,
    output logic [31:0] wbd_adr_o,
    output logic [31:0] wbd_dat_o,
    output logic [3:0]  wbd_sel_o,
    output logic [9:0]  wbd_bl_o,
    input  logic [31:0] wbd_dat_i,
    input  logic        wbd_ack_i,
    input  logic        wbd_lack_i,
    input  logic        wbd_err_i
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    localparam logic [9:0]  MaxBl = 10'(MAX_BL);
    localparam logic [15:0] ToLim = 16'(TIMEOUT_CYC);

    logic [1:0]  state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [9:0]  len_q, len_d;
    logic        err_lat_q, err_lat_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic [9:0]  bl_q, bl_d;
    logic [31:0] rdat_q, rdat_d;
    logic        rvld_q, rvld_d;
    logic        rlast_q, rlast_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic accept;
    logic len_ok;
    logic in_burst;
    logic bus_err;
    logic beat;
    logic last_beat;
    logic short_end;
    logic to_hit;

    // Byte offset is dropped: bursts are always word aligned.
    logic unused_addr;
    assign unused_addr = ^req_addr_i[1:0];

    assign accept    = (state_q == IDLE) && req_valid_i;
    assign len_ok    = (req_len_i != 10'd0) && (req_len_i <= MaxBl);
    assign in_burst  = (state_q == BURST);
    // err_i outranks a simultaneous ack: that beat is discarded.
    assign bus_err   = in_burst && wbd_err_i;
    assign beat      = in_burst && wbd_ack_i && !wbd_err_i;
    assign last_beat = beat && (cnt_q == len_q);
    // lack before the final beat means the slave cut the burst short.
    assign short_end = in_burst && !wbd_err_i && wbd_lack_i && !last_beat;

    assign wdat_pop_o = beat && we_q;

`ifdef YCR1_WB_TIMEOUT_EN
    logic [15:0] to_q, to_d;

    // Watchdog: counts BURST cycles since entry or since the last ack.
    always_comb begin
        to_d = to_q;
        if (state_q == IDLE) begin
            to_d = 16'd0;
        end else if (in_burst) begin
            to_d = wbd_ack_i ? 16'd0 : to_q + 16'd1;
        end
    end

    assign to_hit = in_burst && !wbd_ack_i && ((to_q + 16'd1) == ToLim);

    // Watchdog counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_q <= 16'd0;
        end else begin
            to_q <= to_d;
        end
    end
`else
    logic unused_to;
    assign unused_to = ^ToLim;
    assign to_hit    = 1'b0;
`endif

    // Next-state and output-register logic for the burst sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        err_lat_d = err_lat_q;
        stb_d     = stb_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        bl_d      = bl_q;
        rdat_d    = rdat_q;
        rvld_d    = 1'b0;
        rlast_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (len_ok) begin
                        state_d   = BURST;
                        stb_d     = 1'b1;
                        we_d      = req_we_i;
                        adr_d     = {req_addr_i[31:2], 2'b00};
                        bl_d      = req_len_i;
                        sel_d     = 4'hF;
                        cnt_d     = 10'd1;
                        len_d     = req_len_i;
                        err_lat_d = 1'b0;
                        dat_d     = wdat_i;
                    end else begin
                        // Bad length: no bus cycle, just report the error.
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            BURST: begin
                dat_d = wdat_i;
                if (beat) begin
                    cnt_d = cnt_q + 10'd1;
                    if (!we_q) begin
                        rdat_d  = wbd_dat_i;
                        rvld_d  = 1'b1;
                        rlast_d = (cnt_q == len_q);
                    end
                end
                if (bus_err || last_beat || short_end || to_hit) begin
                    state_d   = GAP;
                    stb_d     = 1'b0;
                    err_lat_d = bus_err || short_end || to_hit;
                end
            end
            GAP: begin
                state_d = IDLE;
                done_d  = 1'b1;
                err_d   = err_lat_q;
            end
            default: begin
                state_d = IDLE;
                stb_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 10'd0;
            len_q     <= 10'd0;
            err_lat_q <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= 32'd0;
            dat_q     <= 32'd0;
            sel_q     <= 4'd0;
            bl_q      <= 10'd0;
            rdat_q    <= 32'd0;
            rvld_q    <= 1'b0;
            rlast_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            err_lat_q <= err_lat_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            bl_q      <= bl_d;
            rdat_q    <= rdat_d;
            rvld_q    <= rvld_d;
            rlast_q   <= rlast_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign wbd_stb_o    = stb_q;
    assign wbd_we_o     = we_q;
    assign wbd_adr_o    = adr_q;
    assign wbd_dat_o    = dat_q;
    assign wbd_sel_o    = sel_q;
    assign wbd_bl_o     = bl_q;
    assign rdat_o       = rdat_q;
    assign rdat_valid_o = rvld_q;
    assign rdat_last_o  = rlast_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule
